axi_led_slave: RTL and testbench

- AXI4-Lite slave that exposes one 32-bit LED control register at byte offset 0x0 and drives the board LED pins from it.
- Any other address is decoded as an error: SLVERR response, read data 0xDEADDEAD.
- Sits on a peripheral AXI-Lite interconnect, one instance per LED bank.

---
 rtl/axi_led_slave.sv | 169 ++++++++++++++++
 tb/tb_axi_led_slave.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_led_slave.sv
// AXI4-Lite slave exposing one LED control register at byte offset 0x0.
// Define AXI_LED_ACTIVE_LOW_EN to drive o_led inverted for active-low boards.
module axi_led_slave #(
  parameter int AXI_ADDR_BW_p = 4,
  parameter int LED_NBR_p     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr,
  input  logic                     i_axi_awvalid,
  output logic                     o_axi_awready,
  input  logic [31:0]              i_axi_wdata,
  input  logic                     i_axi_wvalid,
  output logic                     o_axi_wready,
  output logic [1:0]               o_axi_bresp,
  output logic                     o_axi_bvalid,
  input  logic                     i_axi_bready,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr,
  input  logic                     i_axi_arvalid,
  output logic                     o_axi_arready,
  output logic [31:0]              o_axi_rdata,
  output logic [1:0]               o_axi_rresp,
  output logic                     o_axi_rvalid,
  input  logic                     i_axi_rready,
  output logic [LED_NBR_p-1:0]     o_led
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ERR_DATA    = 32'hDEAD_DEAD;

  function automatic logic addr_ok(input logic [AXI_ADDR_BW_p-1:0] addr);
    return addr == '0;
  endfunction

  logic                 ready_en;
  logic [LED_NBR_p-1:0] led_reg;
  logic [31:0]          led_ext;

  always_comb begin
    led_ext                 = '0;
    led_ext[LED_NBR_p-1:0]  = led_reg;
  end

  // Readies stay low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // ---- Read path: p0 = skid entry, p1 = output response register ----
  logic        r_vld_p0, r_vld_p1;
  logic [31:0] r_data_p0, r_data_p1;
  logic [1:0]  r_resp_p0, r_resp_p1;
  logic        ar_hs, r_hs;
  logic [31:0] ar_data;
  logic [1:0]  ar_resp;

  assign o_axi_arready = ready_en & ~r_vld_p0;
  assign ar_hs         = i_axi_arvalid & o_axi_arready;
  assign r_hs          = r_vld_p1 & i_axi_rready;
  assign ar_data       = addr_ok(i_axi_araddr) ? led_ext : ERR_DATA;
  assign ar_resp       = addr_ok(i_axi_araddr) ? RESP_OKAY : RESP_SLVERR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0  <= 1'b0;
      r_data_p0 <= '0;
      r_resp_p0 <= '0;
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_resp_p1 <= '0;
    end else if (!r_vld_p1 || r_hs) begin
      if (r_vld_p0) begin
        r_vld_p1  <= 1'b1;
        r_data_p1 <= r_data_p0;
        r_resp_p1 <= r_resp_p0;
        r_vld_p0  <= 1'b0;
      end else if (ar_hs) begin
        r_vld_p1  <= 1'b1;
        r_data_p1 <= ar_data;
        r_resp_p1 <= ar_resp;
      end else begin
        r_vld_p1  <= 1'b0;
      end
    end else if (ar_hs) begin
      r_vld_p0  <= 1'b1;
      r_data_p0 <= ar_data;
      r_resp_p0 <= ar_resp;
    end
  end

  assign o_axi_rvalid = r_vld_p1;
  assign o_axi_rdata  = r_data_p1;
  assign o_axi_rresp  = r_resp_p1;

  // ---- Write path p0: independent 2-entry AW and W FIFOs ----
  logic [AXI_ADDR_BW_p-1:0] aw_mem_p0 [2];
  logic [31:0]              w_mem_p0  [2];
  logic                     aw_wr_ptr, aw_rd_ptr, w_wr_ptr, w_rd_ptr;
  logic [1:0]               aw_cnt_p0, w_cnt_p0;
  logic                     aw_push, w_push, wr_exec;
  logic                     b_vld_p1;
  logic [1:0]               b_resp_p1;
  logic [AXI_ADDR_BW_p-1:0] exec_addr;
  logic [31:0]              exec_data;

  assign o_axi_awready = ready_en & (aw_cnt_p0 != 2'd2);
  assign o_axi_wready  = ready_en & (w_cnt_p0 != 2'd2);
  assign aw_push       = i_axi_awvalid & o_axi_awready;
  assign w_push        = i_axi_wvalid & o_axi_wready;
  assign wr_exec       = (aw_cnt_p0 != 2'd0) & (w_cnt_p0 != 2'd0) & (~b_vld_p1 | i_axi_bready);
  assign exec_addr     = aw_mem_p0[aw_rd_ptr];
  assign exec_data     = w_mem_p0[w_rd_ptr];

  always_ff @(posedge clk) begin
    if (aw_push) aw_mem_p0[aw_wr_ptr] <= i_axi_awaddr;
    if (w_push)  w_mem_p0[w_wr_ptr]   <= i_axi_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wr_ptr <= 1'b0;
      aw_rd_ptr <= 1'b0;
      aw_cnt_p0 <= 2'd0;
      w_wr_ptr  <= 1'b0;
      w_rd_ptr  <= 1'b0;
      w_cnt_p0  <= 2'd0;
    end else begin
      if (aw_push) aw_wr_ptr <= ~aw_wr_ptr;
      if (w_push)  w_wr_ptr  <= ~w_wr_ptr;
      if (wr_exec) begin
        aw_rd_ptr <= ~aw_rd_ptr;
        w_rd_ptr  <= ~w_rd_ptr;
      end
      aw_cnt_p0 <= aw_cnt_p0 + 2'(aw_push) - 2'(wr_exec);
      w_cnt_p0  <= w_cnt_p0 + 2'(w_push) - 2'(wr_exec);
    end
  end

  // ---- Write path p1: execute, LED update and B response register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_vld_p1  <= 1'b0;
      b_resp_p1 <= '0;
      led_reg   <= '0;
    end else if (wr_exec) begin
      b_vld_p1 <= 1'b1;
      if (addr_ok(exec_addr)) begin
        b_resp_p1 <= RESP_OKAY;
        led_reg   <= exec_data[LED_NBR_p-1:0];
      end else begin
        b_resp_p1 <= RESP_SLVERR;
      end
    end else if (i_axi_bready) begin
      b_vld_p1 <= 1'b0;
    end
  end

  assign o_axi_bvalid = b_vld_p1;
  assign o_axi_bresp  = b_resp_p1;

`ifdef AXI_LED_ACTIVE_LOW_EN
  assign o_led = ~led_reg;
`else
  assign o_led = led_reg;
`endif

endmodule

// File: tb/tb_axi_led_slave.sv
// Scoreboard bench for axi_led_slave: drivers push expected responses, a negedge monitor checks.
module tb_axi_led_slave;
  localparam int AW = 4;
  localparam int LN = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] i_axi_awaddr = '0;
  logic          i_axi_awvalid = 1'b0;
  logic          o_axi_awready;
  logic [31:0]   i_axi_wdata = '0;
  logic          i_axi_wvalid = 1'b0;
  logic          o_axi_wready;
  logic [1:0]    o_axi_bresp;
  logic          o_axi_bvalid;
  logic          i_axi_bready = 1'b1;
  logic [AW-1:0] i_axi_araddr = '0;
  logic          i_axi_arvalid = 1'b0;
  logic          o_axi_arready;
  logic [31:0]   o_axi_rdata;
  logic [1:0]    o_axi_rresp;
  logic          o_axi_rvalid;
  logic          i_axi_rready = 1'b1;
  logic [LN-1:0] o_led;

  axi_led_slave #(.AXI_ADDR_BW_p(AW), .LED_NBR_p(LN)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_axi_awaddr(i_axi_awaddr), .i_axi_awvalid(i_axi_awvalid), .o_axi_awready(o_axi_awready),
    .i_axi_wdata(i_axi_wdata), .i_axi_wvalid(i_axi_wvalid), .o_axi_wready(o_axi_wready),
    .o_axi_bresp(o_axi_bresp), .o_axi_bvalid(o_axi_bvalid), .i_axi_bready(i_axi_bready),
    .i_axi_araddr(i_axi_araddr), .i_axi_arvalid(i_axi_arvalid), .o_axi_arready(o_axi_arready),
    .o_axi_rdata(o_axi_rdata), .o_axi_rresp(o_axi_rresp), .o_axi_rvalid(o_axi_rvalid),
    .i_axi_rready(i_axi_rready), .o_led(o_led)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] model_led = '0;
  logic [33:0] r_exp_q[$];
  logic [33:0] b_exp_q[$];
  logic        rand_en = 1'b0;
  int          ar_stall = 0;
  int          aw_stall = 0;
  int          w_stall = 0;
  logic [AW-1:0] ra;
  logic [31:0]   rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Monitor: handshake pops and stall stability
  logic        p_rvalid = 1'b0, p_rready = 1'b0, p_bvalid = 1'b0, p_bready = 1'b0;
  logic [31:0] p_rdata = '0;
  logic [1:0]  p_rresp = '0, p_bresp = '0;
  logic [33:0] r_e, b_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_rvalid = 1'b0;
      p_bvalid = 1'b0;
    end else begin
      if (p_rvalid && !p_rready) begin
        check("rvalid_held", 32'(o_axi_rvalid), 32'd1);
        check("rdata_stable", o_axi_rdata, p_rdata);
        check("rresp_stable", 32'(o_axi_rresp), 32'(p_rresp));
      end
      if (p_bvalid && !p_bready) begin
        check("bvalid_held", 32'(o_axi_bvalid), 32'd1);
        check("bresp_stable", 32'(o_axi_bresp), 32'(p_bresp));
      end
      if (o_axi_rvalid && i_axi_rready) begin
        if (r_exp_q.size() == 0) check("r_unexpected", 32'd1, 32'd0);
        else begin
          r_e = r_exp_q.pop_front();
          check("rdata", o_axi_rdata, r_e[31:0]);
          check("rresp", 32'(o_axi_rresp), 32'(r_e[33:32]));
        end
      end
      if (o_axi_bvalid && i_axi_bready) begin
        if (b_exp_q.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else begin
          b_e = b_exp_q.pop_front();
          check("bresp", 32'(o_axi_bresp), 32'(b_e[33:32]));
          check("led_at_b", o_led, b_e[31:0]);
        end
      end
      p_rvalid = o_axi_rvalid; p_rready = i_axi_rready;
      p_rdata = o_axi_rdata;   p_rresp = o_axi_rresp;
      p_bvalid = o_axi_bvalid; p_bready = i_axi_bready;
      p_bresp = o_axi_bresp;
    end
  end

  // Random ready toggling while enabled
  initial forever begin
    @(posedge clk); #1;
    if (rand_en) begin
      i_axi_rready = 1'($urandom_range(0, 1));
      i_axi_bready = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_read(input logic [AW-1:0] a);
    int   t = 0;
    logic acc = 1'b0;
    i_axi_araddr = a; i_axi_arvalid = 1'b1;
    while (!acc && t < 60) begin
      @(negedge clk);
      if (o_axi_arready) begin
        acc = 1'b1;
        r_exp_q.push_back((a == '0) ? {2'b00, model_led} : {2'b10, 32'hDEAD_DEAD});
      end else ar_stall++;
      @(posedge clk); #1;
      t++;
    end
    i_axi_arvalid = 1'b0;
    if (!acc) check("ar_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_aw(input logic [AW-1:0] a);
    int   t = 0;
    logic acc = 1'b0;
    i_axi_awaddr = a; i_axi_awvalid = 1'b1;
    while (!acc && t < 100) begin
      @(negedge clk);
      if (o_axi_awready) acc = 1'b1; else aw_stall++;
      @(posedge clk); #1;
      t++;
    end
    i_axi_awvalid = 1'b0;
    if (!acc) check("aw_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_w(input logic [31:0] d);
    int   t = 0;
    logic acc = 1'b0;
    i_axi_wdata = d; i_axi_wvalid = 1'b1;
    while (!acc && t < 100) begin
      @(negedge clk);
      if (o_axi_wready) acc = 1'b1; else w_stall++;
      @(posedge clk); #1;
      t++;
    end
    i_axi_wvalid = 1'b0;
    if (!acc) check("w_timeout", 32'd0, 32'd1);
  endtask

  // mode 0: AW and W together, 1: W three cycles before AW, 2: AW then W
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input int mode);
    if (a == '0) model_led = d;
    b_exp_q.push_back({(a == '0) ? 2'b00 : 2'b10, model_led});
    case (mode)
      0: fork
           send_aw(a);
           send_w(d);
         join
      1: begin
           send_w(d);
           repeat (3) @(posedge clk);
           #1;
           send_aw(a);
         end
      default: begin
           send_aw(a);
           send_w(d);
         end
    endcase
  endtask

  task automatic wait_drain();
    int t = 0;
    rand_en = 1'b0;
    @(posedge clk); #1;
    i_axi_rready = 1'b1; i_axi_bready = 1'b1;
    while ((r_exp_q.size() != 0 || b_exp_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (r_exp_q.size() != 0 || b_exp_q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_arready", 32'(o_axi_arready), 32'd0);
    check("rst_awready", 32'(o_axi_awready), 32'd0);
    check("rst_rvalid", 32'(o_axi_rvalid), 32'd0);
    check("rst_bvalid", 32'(o_axi_bvalid), 32'd0);
    check("rst_rdata", o_axi_rdata, 32'd0);
    check("rst_led", o_led, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rel_arready", 32'(o_axi_arready), 32'd1);
    check("rel_wready", 32'(o_axi_wready), 32'd1);
    @(posedge clk); #1;

    // Basic valid and invalid accesses
    do_write(4'h0, 32'hA5A5_1234, 0);
    wait_drain();
    do_read(4'h0);
    wait_drain();
    do_write(4'h4, 32'h1111_1111, 2);
    wait_drain();
    check("led_unchanged", o_led, 32'hA5A5_1234);
    do_read(4'h8);
    do_read(4'h2);
    wait_drain();

    // Read skid: two accepted while stalled, third blocked
    i_axi_rready = 1'b0;
    do_read(4'h0);
    do_read(4'h0);
    i_axi_araddr = 4'h0; i_axi_arvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ar_blocked", 32'(o_axi_arready), 32'd0);
    end
    @(posedge clk); #1;
    i_axi_rready = 1'b1;
    do_read(4'h0);
    wait_drain();

    // Write buffering with B stalled
    i_axi_bready = 1'b0;
    do_write(4'h0, 32'h0000_BEEF, 1);
    do_write(4'hC, 32'h1234_5678, 2);
    do_write(4'h0, 32'hCAFE_F00D, 0);
    @(negedge clk);
    check("aw_full", 32'(o_axi_awready), 32'd0);
    check("w_full", 32'(o_axi_wready), 32'd0);
    check("b_pending", 32'(o_axi_bvalid), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    wait_drain();

    // Throughput: back-to-back reads and writes with ready high
    ar_stall = 0;
    for (int i = 0; i < 5; i++) do_read((i % 2 == 0) ? 4'h0 : 4'h4);
    @(negedge clk); #1;
    check("ar_no_stall", 32'(ar_stall), 32'd0);
    check("r_one_per_cycle", 32'(r_exp_q.size()), 32'd0);
    @(posedge clk); #1;
    aw_stall = 0; w_stall = 0;
    for (int i = 0; i < 5; i++) do_write(4'h0, $urandom, 0);
    check("aw_no_stall", 32'(aw_stall), 32'd0);
    check("w_no_stall", 32'(w_stall), 32'd0);
    wait_drain();

    // Randomized writes then reads with random ready back-pressure
    rand_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 2) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rd = $urandom;
      do_write(ra, rd, int'($urandom_range(0, 2)));
    end
    wait_drain();
    rand_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
      do_read(ra);
    end
    wait_drain();

    // Reset while responses pending
    i_axi_rready = 1'b0; i_axi_bready = 1'b0;
    do_write(4'h0, 32'h0F0F_00FF, 0);
    do_read(4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(o_axi_rvalid), 32'd0);
    check("mid_rst_bvalid", 32'(o_axi_bvalid), 32'd0);
    check("mid_rst_led", o_led, 32'd0);
    r_exp_q.delete();
    b_exp_q.delete();
    model_led = '0;
    i_axi_rready = 1'b1; i_axi_bready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rel2_arready", 32'(o_axi_arready), 32'd1);
    check("rel2_awready", 32'(o_axi_awready), 32'd1);
    check("rel2_wready", 32'(o_axi_wready), 32'd1);
    @(posedge clk); #1;
    do_read(4'h0);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
